// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump engine.
//   state_e        : dump sequencer states, also exported as a debug port
//   nreg_of()      : register count for a given address width
//   DUMP_WORDS_MAX : longest possible dump (whole file) at the default width
package regdump_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam int DEF_AW = 3;

  function automatic int nreg_of(input int aw);
    return 1 << aw;
  endfunction

  localparam int DUMP_WORDS_MAX = nreg_of(DEF_AW);

endpackage

// File: rtl/regfile_dumper.sv
// regfile_dumper: walks an address range of the register file on its second
// read port and streams (address, data) pairs to a debug sink.
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous active-low reset
//   start      one-cycle dump request, ignored while busy
//   first/last inclusive address range, latched when start is accepted;
//              the range wraps modulo the register count when first > last
//   ra         read address driven to the register file
//   rd         combinational read data for ra
//   out_*      output word stream
//   busy       high from the cycle after an accepted start through done
//   done       one-cycle pulse after the final word is taken
//   dbg_state  current sequencer state
//
// Output stream handshake: a word transfers on a rising clock edge where
// out_valid && out_ready. Once out_valid rises, out_addr/out_data stay
// unchanged until that transfer; out_ready while out_valid is low is ignored.
module regfile_dumper
  import regdump_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] ra,
  input  logic [N-1:0]  rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [N-1:0]  out_data,
  output logic          busy,
  output logic          done,
  output state_e        dbg_state
);

  state_e        r_state;
  state_e        w_next;
  logic [AW-1:0] r_cur;
  logic [AW-1:0] r_end;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] r_out_addr;
  logic [N-1:0]  r_out_data;
  logic          w_hs;
  logic [AW-1:0] w_cur_inc;

  assign w_hs      = (r_state == S_SEND) && out_ready;
  // Plain AW-bit increment: the wrap from NREG-1 to 0 is the range wrap.
  assign w_cur_inc = r_cur + AW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = S_SEND;
      S_SEND: if (w_hs) w_next = (r_cur == r_end) ? S_FIN : S_READ;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_FIN);
    out_valid = (r_state == S_SEND);
  end

  // Datapath: range counter, read address and captured output word.
  // ra is only updated on start and on advancing, so it holds in IDLE/FIN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cur      <= '0;
      r_end      <= '0;
      r_ra       <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur <= first;
            r_end <= last;
            r_ra  <= first;
          end
        end
        S_READ: begin
          // rd is combinational from ra, which equals r_cur in this state
          r_out_addr <= r_cur;
          r_out_data <= rd;
        end
        S_SEND: begin
          if (w_hs && (r_cur != r_end)) begin
            r_cur <= w_cur_inc;
            r_ra  <= w_cur_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign ra        = r_ra;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;

endmodule

// File: doc/regfile_dumper.md
Name: regfile_dumper

Overview:
Sequential reader for the 8x8 register file: on a start pulse it walks a latched address range, driving the read-address port and sampling the combinational read data. Each (address, data) pair is emitted on a valid/ready output stream toward a display/serial sink. It is used for debug dump of CPU architectural state, and sits beside the register file on its second read port.

Parameters:
N, 8, data width of each register word
AW, 3, register address width; register count NREG = 2**AW

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  reset, synchronous, active-low
start  input  1  one-cycle request to begin a dump; ignored while busy=1
first  input  AW  first address of range, latched on accepted start
last  input  AW  last address of range, latched on accepted start
ra  output  AW  read address to register file read port
rd  input  N  combinational read data from register file (valid same cycle as ra)
out_valid  output  1  output word valid
out_ready  input  1  sink accepts word when out_valid&&out_ready at posedge
out_addr  output  AW  address of emitted word
out_data  output  N  data of emitted word
busy  output  1  high from cycle after accepted start until done pulse inclusive
done  output  1  one-cycle pulse after last word handshake

Behaviour:
- Reset (rst=0 at posedge): state IDLE; ra=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0; latched range cleared. Reset wins over all other inputs, including mid-dump; an in-flight word is dropped, no done pulse.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE: on start=1 latch cur<=first, end<=last, ra<=first, busy<=1 -> READ.
- READ (one cycle): ra=cur; at posedge capture out_data<=rd, out_addr<=cur, out_valid<=1 -> SEND.
- SEND: hold out_valid/out_addr/out_data stable until handshake. On handshake: out_valid<=0; if cur==end -> FIN; else cur<=cur+1 (AW-bit wrap), ra<=cur+1 -> READ.
- FIN: done=1, busy=1 for exactly one cycle -> IDLE (busy<=0, done<=0).
- Address arithmetic is modulo NREG: first>last wraps through NREG-1 to 0. Word count = ((last-first) mod NREG)+1. first==last gives 1 word; last==first-1 gives all NREG words.
- Latency: start at cycle T -> ra=first during T+1 -> out_valid=1 at T+2. With out_ready held 1, throughput is 1 word per 2 cycles. A k-word dump gives done at T+2k+1.
- ra holds its last value in IDLE/FIN (no spurious change).
- start during busy: ignored; first/last changes during busy have no effect.
- start in the same cycle as FIN: ignored (FIN is busy). Accepted next cycle in IDLE.
- out_ready with out_valid=0: no effect.
- Register contents changing mid-dump: each word reflects rd sampled in its own READ cycle (no snapshot of whole file).

Decomposition:
- Package regdump_pkg: state enum typedef (IDLE, READ, SEND, FIN), localparam NREG derivation helper, constant DUMP_WORDS_MAX=NREG.
- Single module; no sub-module needed. The address counter is inline (one AW-bit register with wrap).

Test Plan:
- Regfile preloaded r0..r7 = 00,11,22,...,77. Pulse start, first=0, last=7, out_ready=1 -> 8 words addr 0..7 data 00..77, one per 2 cycles. First out_valid 2 cycles after start; done 17 cycles after start; busy low the cycle after done.
- Wrap: first=6, last=1 -> words addr 6,7,0,1 with data 66,77,00,11, then done.
- Single word: first=last=3 -> one word (3, 33), done 3 cycles after start.
- Backpressure: first=2, last=4, out_ready low for 5 cycles during word 2 -> out_valid/addr/data (2,22) stable throughout. Then words 3,4 in order; no word lost or duplicated.
- Start ignored: second start with first=0 while busy -> sequence unchanged. Start asserted in FIN cycle -> no new dump.
- Reset mid-dump: rst=0 during SEND of word 5 of 0..7 -> next cycle all outputs 0, state IDLE, no done. A new start then runs normally from its own first.
